// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory loader.
package riscv_pkg;
  typedef enum logic [1:0] {HDR, LOAD, DONE, ERR} loader_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int WORD_W      = 32;
  localparam int BYTE_CNT_W  = $clog2(INSTR_BYTES);
endpackage

// File: rtl/instr_loader_byte_packer.sv
// Collects accepted bytes into little-endian 32-bit words; o_word_valid pulses
// combinationally in the cycle the 4th byte of a word is accepted.
module byte_packer
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic [7:0]            i_byte,
  output logic [WORD_W-1:0]     o_word,
  output logic                  o_word_valid,
  output logic [BYTE_CNT_W-1:0] o_cnt
);
  localparam logic [BYTE_CNT_W-1:0] LAST = BYTE_CNT_W'(INSTR_BYTES - 1);

  logic [BYTE_CNT_W-1:0] r_cnt;
  logic [WORD_W-9:0]     r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_lo  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_accept) begin
      case (r_cnt)
        2'd0:    r_lo[7:0]   <= i_byte;
        2'd1:    r_lo[15:8]  <= i_byte;
        2'd2:    r_lo[23:16] <= i_byte;
        default: ;
      endcase
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The top byte is never stored: the word is complete as it arrives.
  assign o_word       = {i_byte, r_lo};
  assign o_word_valid = i_accept && !i_clear && (r_cnt == LAST);
  assign o_cnt        = r_cnt;
endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction-memory loader: reads an N-word image from a byte stream,
// writes it to consecutive addresses and holds the core in reset until complete.
// Handshake: a byte transfers on a rising CLK edge where rx_valid && rx_ready;
// rx_ready is registered and never depends on rx_valid in the same cycle.
module instr_loader
  import riscv_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              WR_MEM_INSTR,
  output logic [WORD_W-1:0] WRITE_INSTRUCTION,
  output logic [31:0]       INSTR_ADDR,
  output logic              CORE_RST,
  output logic              done,
  output logic              err,
  output loader_state_t     dbg_state
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

  loader_state_t         r_state, w_next;
  logic                  r_ready, r_wr;
  logic [WORD_W-1:0]     r_wdata;
  logic [31:0]           r_addr;
  logic [CW-1:0]         r_count, r_index;
  logic [IW-1:0]         r_idle;
  logic                  w_accept, w_rearm, w_idle_run, w_timeout, w_clear;
  logic                  w_word_valid;
  logic [WORD_W-1:0]     w_word;
  logic [BYTE_CNT_W-1:0] w_cnt;

  assign w_accept   = rx_valid && r_ready;
  assign w_rearm    = load_req && ((r_state == DONE) || (r_state == ERR));
  // Idle time only counts once the header has started arriving.
  assign w_idle_run = !w_accept &&
                      ((r_state == LOAD) || ((r_state == HDR) && (w_cnt != '0)));
  assign w_timeout  = w_idle_run && (r_idle == IW'(TIMEOUT_CYC - 1));
  assign w_clear    = w_timeout || w_rearm;

  byte_packer u_packer (
    .clk          (CLK),
    .rst_n        (RST),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_cnt        (w_cnt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= HDR;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR: begin
        if (w_word_valid) begin
          if (w_word == '0)          w_next = DONE;
          else if (w_word > DEPTH_W) w_next = ERR;
          else                       w_next = LOAD;
        end else if (w_timeout) begin
          w_next = ERR;
        end
      end
      // Leave LOAD only after the final strobe cycle so it never overlaps DONE.
      LOAD: begin
        if (r_wr && (r_index == r_count)) w_next = DONE;
        else if (w_timeout)               w_next = ERR;
      end
      DONE, ERR: if (load_req) w_next = HDR;
      default:   w_next = HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ready <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_index <= '0;
      r_idle  <= '0;
    end else begin
      r_ready <= (w_next == HDR) || (w_next == LOAD);
      r_wr    <= (r_state == LOAD) && w_word_valid;
      if ((r_state == HDR) && w_word_valid) r_count <= w_word[CW-1:0];
      if ((r_state == LOAD) && w_word_valid) begin
        r_wdata <= w_word;
        r_addr  <= BASE_ADDR + (32'(r_index) << 2);
        r_index <= r_index + 1'b1;
      end
      if (w_rearm) begin
        r_count <= '0;
        r_index <= '0;
      end
      if (w_accept || w_rearm) r_idle <= '0;
      else if (w_idle_run)     r_idle <= r_idle + 1'b1;
    end
  end

  assign rx_ready          = r_ready;
  assign WR_MEM_INSTR      = r_wr;
  assign WRITE_INSTRUCTION = r_wdata;
  assign INSTR_ADDR        = r_addr;
  assign CORE_RST          = (r_state != DONE);
  assign done              = (r_state == DONE);
  assign err               = (r_state == ERR);
  assign dbg_state         = r_state;
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a queue-based image model predicts every output each
// cycle; directed scenarios add literal expectations through a write scoreboard.
module tb_instr_loader;
  import riscv_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0100;  // non-zero so address offsets are visible
  localparam int          TMO   = 16;

  logic          clk, rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_ready, load_req;
  logic          WR_MEM_INSTR, CORE_RST, done, err;
  logic [31:0]   WRITE_INSTRUCTION, INSTR_ADDR;
  loader_state_t dbg_state;

  instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)) dut (
    .CLK               (clk),
    .RST               (rst_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .load_req          (load_req),
    .WR_MEM_INSTR      (WR_MEM_INSTR),
    .WRITE_INSTRUCTION (WRITE_INSTRUCTION),
    .INSTR_ADDR        (INSTR_ADDR),
    .CORE_RST          (CORE_RST),
    .done              (done),
    .err               (err),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  loader_state_t m_state;
  logic          m_ready, m_wr;
  logic [31:0]   m_wdata, m_addr;
  logic [7:0]    m_bytes[$];
  longint        m_n;
  int            m_idx, m_idle;

  task automatic model_reset();
    m_state = HDR;
    m_ready = 1'b0;
    m_wr    = 1'b0;
    m_wdata = '0;
    m_addr  = BASE;
    m_bytes.delete();
    m_n     = 0;
    m_idx   = 0;
    m_idle  = 0;
  endtask

  task automatic model_step();
    logic        acc, wr_prev;
    logic [31:0] w;
    acc     = rx_valid && m_ready;
    wr_prev = m_wr;
    m_wr    = 1'b0;
    if (m_state == HDR || m_state == LOAD) begin
      if (acc) begin
        m_bytes.push_back(rx_data);
        m_idle = 0;
      end else if (m_state == LOAD || m_bytes.size() != 0) begin
        m_idle++;
      end
      if (m_bytes.size() == 4) begin
        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_bytes.delete();
        if (m_state == HDR) begin
          m_n   = longint'(w);
          m_idx = 0;
          if (m_n == 0)          m_state = DONE;
          else if (m_n > DEPTH)  m_state = ERR;
          else                   m_state = LOAD;
        end else begin
          m_wr    = 1'b1;
          m_wdata = w;
          m_addr  = BASE + 32'(4 * m_idx);
          m_idx++;
        end
      end else if (m_state == LOAD && wr_prev && (m_idx - 1 == m_n - 1)) begin
        m_state = DONE;
      end else if (m_idle == TMO) begin
        m_state = ERR;
        m_bytes.delete();
      end
    end else if (load_req) begin
      m_state = HDR;
      m_bytes.delete();
      m_idx  = 0;
      m_idle = 0;
    end
    m_ready = (m_state == HDR) || (m_state == LOAD);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("rx_ready",   64'(rx_ready),     64'(m_ready));
      chk("wr_strobe",  64'(WR_MEM_INSTR), 64'(m_wr));
      if (m_wr) chk("wr_data", 64'(WRITE_INSTRUCTION), 64'(m_wdata));
      chk("instr_addr", 64'(INSTR_ADDR),   64'(m_addr));
      chk("core_rst",   64'(CORE_RST),     64'(m_state != DONE));
      chk("done",       64'(done),         64'(m_state == DONE));
      chk("err",        64'(err),          64'(m_state == ERR));
      chk("state",      64'(dbg_state),    64'(m_state));
    end
  end

  // ---------------- write scoreboard (directed scenarios) ----------------
  logic [63:0] exp_q[$];
  logic        sb_en;

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (sb_en && WR_MEM_INSTR) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 64'(WR_MEM_INSTR), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_write", {INSTR_ADDR, WRITE_INSTRUCTION}, e);
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  logic lr_noise;

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited   = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    load_req = lr_noise && ($urandom_range(0, 3) == 0);
    while (!rx_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) chk("send_accept_timeout", 64'(rx_ready), 64'(1));
    else @(negedge clk);
    rx_valid = 1'b0;
    load_req = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], (k == 3 && gmax == 0) ? 0 : $urandom_range(gmin, gmax));
    end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!(done || err) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done_or_err", 64'(done || err), 64'(1));
  endtask

  task automatic offer_ignored(input int n);
    repeat (n) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [31:0] w1, w2, w3, w4, w5, w6, hdr;
    int          sel;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; load_req = 1'b0;
    sb_en = 1'b1; lr_noise = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready),          64'(0));
    chk("rst_wr",       64'(WR_MEM_INSTR),      64'(0));
    chk("rst_wdata",    64'(WRITE_INSTRUCTION), 64'(0));
    chk("rst_addr",     64'(INSTR_ADDR),        64'(32'h0000_0100));
    chk("rst_core_rst", 64'(CORE_RST),          64'(1));
    chk("rst_done",     64'(done),              64'(0));
    chk("rst_err",      64'(err),               64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);

    // nominal two-word image, back-to-back bytes
    exp_q.push_back({32'h0000_0100, 32'h0000_0013});
    exp_q.push_back({32'h0000_0104, 32'h0010_0093});
    send_word(32'd2, 0, 0);
    send_word(32'h0000_0013, 0, 0);
    send_word(32'h0010_0093, 0, 0);
    chk("nom_last_strobe",   64'(WR_MEM_INSTR), 64'(1));
    chk("nom_last_addr",     64'(INSTR_ADDR),   64'(32'h0000_0104));
    chk("nom_core_rst_held", 64'(CORE_RST),     64'(1));
    @(negedge clk);
    chk("nom_core_rst_fall", 64'(CORE_RST),     64'(0));
    chk("nom_done",          64'(done),         64'(1));
    chk("nom_strobe_off",    64'(WR_MEM_INSTR), 64'(0));
    chk("nom_sb_drain",      64'(exp_q.size()), 64'(0));
    offer_ignored(3);
    chk("done_no_accept",    64'(rx_ready),     64'(0));

    // empty image
    pulse_load_req();
    chk("empty_rearm_core_rst", 64'(CORE_RST), 64'(1));
    chk("empty_rearm_done",     64'(done),     64'(0));
    send_word(32'd0, 0, 0);
    chk("empty_done",     64'(done),     64'(1));
    chk("empty_core_rst", 64'(CORE_RST), 64'(0));

    // oversize header
    pulse_load_req();
    send_word(32'h0000_0101, 0, 0);
    chk("over_err",      64'(err),      64'(1));
    chk("over_core_rst", 64'(CORE_RST), 64'(1));
    chk("over_rx_ready", 64'(rx_ready), 64'(0));
    offer_ignored(4);
    chk("over_sb_drain", 64'(exp_q.size()), 64'(0));

    // timeout after a partial word
    pulse_load_req();
    send_word(32'd1, 0, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    repeat (15) @(negedge clk);
    chk("tmo_not_yet", 64'(err), 64'(0));
    @(negedge clk);
    chk("tmo_err",      64'(err),           64'(1));
    chk("tmo_sb_drain", 64'(exp_q.size()),  64'(0));

    // gapped valid, then reload
    pulse_load_req();
    w1 = $urandom; w2 = $urandom;
    exp_q.push_back({BASE, w1});
    exp_q.push_back({BASE + 32'd4, w2});
    send_word(32'd2, 1, 1);
    send_word(w1, 1, 1);
    send_word(w2, 1, 1);
    wait_done(10);
    chk("gap_sb_drain", 64'(exp_q.size()), 64'(0));
    pulse_load_req();
    chk("reload_core_rst", 64'(CORE_RST), 64'(1));
    w3 = $urandom;
    exp_q.push_back({BASE, w3});
    send_word(32'd1, 1, 1);
    send_word(w3, 1, 1);
    wait_done(10);
    chk("reload_done",     64'(done),         64'(1));
    chk("reload_sb_drain", 64'(exp_q.size()), 64'(0));

    // asynchronous reset in the middle of LOAD
    pulse_load_req();
    w4 = $urandom;
    exp_q.push_back({BASE, w4});
    send_word(32'd3, 0, 0);
    send_word(w4, 0, 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rx_ready", 64'(rx_ready),          64'(0));
    chk("arst_wr",       64'(WR_MEM_INSTR),      64'(0));
    chk("arst_wdata",    64'(WRITE_INSTRUCTION), 64'(0));
    chk("arst_addr",     64'(INSTR_ADDR),        64'(32'h0000_0100));
    chk("arst_core_rst", 64'(CORE_RST),          64'(1));
    chk("arst_state",    64'(dbg_state),         64'(HDR));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    w5 = $urandom; w6 = $urandom;
    exp_q.push_back({BASE, w5});
    exp_q.push_back({BASE + 32'd4, w6});
    send_word(32'd2, 0, 1);
    send_word(w5, 0, 1);
    send_word(w6, 0, 1);
    wait_done(10);
    chk("arst_reload_done",     64'(done),         64'(1));
    chk("arst_reload_sb_drain", 64'(exp_q.size()), 64'(0));

    // randomized images checked by the model alone
    sb_en    = 1'b0;
    lr_noise = 1'b1;
    for (int it = 0; it < 10; it++) begin
      pulse_load_req();
      sel = $urandom_range(0, 9);
      if (it == 0)        hdr = 32'(DEPTH);
      else if (sel == 0)  hdr = 32'd0;
      else if (sel == 1)  hdr = 32'(DEPTH + 1) + 32'($urandom_range(0, 100));
      else if (sel == 2)  hdr = $urandom | 32'h8000_0000;
      else                hdr = 32'($urandom_range(1, 6));
      send_word(hdr, 0, 2);
      if (hdr != 0 && hdr <= 32'(DEPTH)) begin
        for (int j = 0; j < int'(hdr); j++) send_word($urandom, 0, 2);
      end
      wait_done(20);
      offer_ignored($urandom_range(1, 4));
    end
    lr_noise = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
